// File: rtl/sr_cmd_gen.sv
// Debounced set/reset pulse generator for a downstream SR flop, with
// immediate force commands and a wrapping pulse counter.
module sr_cmd_gen #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       force_set,
    input  logic       force_clr,
    output logic       s,
    output logic       r,
    output logic       state,
    output logic       busy,
    output logic [7:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FIRE
    } fsm_t;

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    fsm_t       fsm, fsm_n;
    logic [3:0] cnt, cnt_n;
    logic       tgt, tgt_n;
    logic       state_n;
    logic [7:0] pulse_cnt_n;
    logic       s_n, r_n, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= '0;
            tgt       <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            state     <= 1'b0;
            busy      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            fsm       <= fsm_n;
            cnt       <= cnt_n;
            tgt       <= tgt_n;
            s         <= s_n;
            r         <= r_n;
            state     <= state_n;
            busy      <= busy_n;
            pulse_cnt <= pulse_cnt_n;
        end
    end

    always_comb begin
        fsm_n       = fsm;
        cnt_n       = cnt;
        tgt_n       = tgt;
        state_n     = state;
        pulse_cnt_n = pulse_cnt;
        case (fsm)
            IDLE, CHECK: begin
                if (force_set) begin
                    fsm_n = FIRE;
                    tgt_n = 1'b1;
                    cnt_n = '0;
                end else if (force_clr) begin
                    fsm_n = FIRE;
                    tgt_n = 1'b0;
                    cnt_n = '0;
                end else if (din == state) begin
                    fsm_n = IDLE;
                    cnt_n = '0;
                end else if (fsm == IDLE) begin
                    fsm_n = CHECK;
                    cnt_n = 4'd1;
                end else if (cnt == CNT_LAST) begin
                    fsm_n = FIRE;
                    tgt_n = din;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            FIRE: begin
                state_n     = tgt;
                pulse_cnt_n = pulse_cnt + 8'd1;
                fsm_n       = IDLE;
                cnt_n       = '0;
            end
            default: begin
                fsm_n = IDLE;
                cnt_n = '0;
            end
        endcase
        // Pulse outputs are registered from the next state so s/r coincide with FIRE.
        s_n    = (fsm_n == FIRE) && tgt_n;
        r_n    = (fsm_n == FIRE) && !tgt_n;
        busy_n = (fsm_n != IDLE);
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: directed scenarios plus randomized
// traffic compared against a run-length reference model.
module tb_sr_cmd_gen;

    localparam int unsigned SC = 4;

    logic       clk;
    logic       rst;
    logic       din;
    logic       force_set;
    logic       force_clr;
    logic       s;
    logic       r;
    logic       state;
    logic       busy;
    logic [7:0] pulse_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: mismatch run length and a pending one-cycle pulse.
    int         m_run;
    logic       m_fire;
    logic       m_tgt;
    logic       m_state;
    logic [7:0] m_pcnt;

    sr_cmd_gen #(.STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .force_set (force_set),
        .force_clr (force_clr),
        .s         (s),
        .r         (r),
        .state     (state),
        .busy      (busy),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic i_rst, input logic i_din, input logic i_fs, input logic i_fc);
        if (i_rst) begin
            m_run = 0; m_fire = 1'b0; m_tgt = 1'b0; m_state = 1'b0; m_pcnt = 8'd0;
        end else if (m_fire) begin
            m_state = m_tgt;
            m_pcnt  = m_pcnt + 8'd1;
            m_fire  = 1'b0;
            m_run   = 0;
        end else if (i_fs || i_fc) begin
            m_fire = 1'b1;
            m_tgt  = i_fs;
            m_run  = 0;
        end else if (i_din != m_state) begin
            m_run = m_run + 1;
            if (m_run == SC) begin
                m_fire = 1'b1;
                m_tgt  = i_din;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic step(input logic i_rst, input logic i_din, input logic i_fs, input logic i_fc);
        rst = i_rst; din = i_din; force_set = i_fs; force_clr = i_fc;
        @(posedge clk);
        model_edge(i_rst, i_din, i_fs, i_fc);
        #1;
        check("s", {7'd0, s}, {7'd0, m_fire && m_tgt});
        check("r", {7'd0, r}, {7'd0, m_fire && !m_tgt});
        check("state", {7'd0, state}, {7'd0, m_state});
        check("busy", {7'd0, busy}, {7'd0, m_fire || (m_run > 0)});
        check("pulse_cnt", pulse_cnt, m_pcnt);
        check("s_and_r", {7'd0, s & r}, 8'd0);
    endtask

    initial begin
        logic last_tgt;
        logic fs, fc;
        logic cur_din;

        m_run = 0; m_fire = 1'b0; m_tgt = 1'b0; m_state = 1'b0; m_pcnt = 8'd0;

        // Reset for two cycles with din low.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_s", {7'd0, s}, 8'd0);
        check("rst_r", {7'd0, r}, 8'd0);
        check("rst_state", {7'd0, state}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_pcnt", pulse_cnt, 8'd0);

        // din rises and holds: s after the 4th sampling edge, exactly one cycle.
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0);
            check("hold_s", {7'd0, s}, {7'd0, i == 4});
        end
        step(0, 1, 0, 0);
        check("hold_s_off", {7'd0, s}, 8'd0);
        check("hold_state", {7'd0, state}, 8'd1);
        check("hold_pcnt", pulse_cnt, 8'd1);
        check("hold_busy", {7'd0, busy}, 8'd0);

        // Two-cycle glitch low is rejected.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("glitch_busy", {7'd0, busy}, 8'd1);
        step(0, 1, 0, 0);
        check("glitch_busy_off", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("glitch_state", {7'd0, state}, 8'd1);
        check("glitch_pcnt", pulse_cnt, 8'd1);

        // Clear via force, then both forces high: set wins.
        step(0, 0, 0, 1);
        check("fclr_r", {7'd0, r}, 8'd1);
        step(0, 0, 0, 0);
        check("fclr_state", {7'd0, state}, 8'd0);
        step(0, 0, 1, 1);
        check("both_s", {7'd0, s}, 8'd1);
        check("both_r", {7'd0, r}, 8'd0);
        step(0, 0, 0, 0);
        check("both_state", {7'd0, state}, 8'd1);

        // Reset aborts qualification mid-CHECK.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("abort_s", {7'd0, s}, 8'd0);
        check("abort_state", {7'd0, state}, 8'd0);
        check("abort_pcnt", pulse_cnt, 8'd0);
        // Release with din high: pulse no earlier than the normal latency.
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0);
            check("rel_s", {7'd0, s}, {7'd0, i == 4});
        end
        step(0, 1, 0, 0);

        // 256 forced pulses from reset wrap pulse_cnt to zero.
        step(1, 0, 0, 0);
        last_tgt = 1'b0;
        for (int i = 0; i < 256; i++) begin
            fs = 1'($urandom_range(0, 1));
            fc = ~fs | 1'($urandom_range(0, 1));
            last_tgt = fs;
            step(0, 0, fs, fc);
            step(0, 0, 0, 0);
        end
        check("wrap_pcnt", pulse_cnt, 8'd0);
        check("wrap_state", {7'd0, state}, {7'd0, last_tgt});

        // Randomized traffic: held din runs, occasional forces and resets.
        cur_din = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur_din = ~cur_din;
            fs = ($urandom_range(0, 24) == 0);
            fc = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 199) == 0, cur_din, fs, fc);
        end

        // Alternating din never fires.
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1'(i % 2 == 0), 0, 0);
        check("toggle_pcnt", pulse_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive sampled cycles din must differ from tracked state before a pulse is issued; legal range 2..15.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  1  level request to be mirrored onto a downstream set/reset flop; synchronous to clk.
REQ-005 force_set  input  1  immediate set command, bypasses debounce.
REQ-006 force_clr  input  1  immediate clear command, bypasses debounce.
REQ-007 s  output  1  registered set pulse to downstream flop.
REQ-008 r  output  1  registered reset pulse to downstream flop.
REQ-009 state  output  1  tracked level of downstream flop.
REQ-010 busy  output  1  high while a change is being qualified or issued.
REQ-011 pulse_cnt  output  8  count of pulses issued, wraps 255->0.

Function
REQ-012 FSM states IDLE, CHECK, FIRE; internal 4-bit stability counter cnt; all outputs registered.
REQ-013 IDLE: force requests absent and din==state -> stay IDLE, cnt=0; din!=state -> CHECK, cnt=1.
REQ-014 CHECK: din==state -> IDLE, cnt=0 (glitch rejected, no pulse); din!=state and cnt==STABLE_CYCLES-1 -> FIRE with target=din; else cnt+1.
REQ-015 Net debounce latency: s/r asserted in the cycle following the STABLE_CYCLES-th consecutive rising edge that samples din!=state.
REQ-016 FIRE lasts exactly one cycle: s=1 if target=1, r=1 if target=0; s and r never high together; next edge state<=target, pulse_cnt+1, FSM->IDLE, cnt=0.
REQ-017 Force in IDLE or CHECK: force_set -> FIRE target=1; force_clr -> FIRE target=0; both high -> force_set wins; pulse appears one cycle after sampling edge; cnt cleared.
REQ-018 Force or din activity during FIRE ignored; re-evaluated from IDLE on following cycles.
REQ-019 Redundant request (force target equals state) still issues one pulse and increments pulse_cnt; state unchanged.
REQ-020 busy=1 in CHECK and FIRE, 0 in IDLE.
REQ-021 pulse_cnt 255 + pulse -> 0, no flag.
REQ-022 din toggling every cycle never reaches FIRE for STABLE_CYCLES>=2.

Reset
REQ-023 rst has priority over all inputs: FSM=IDLE, cnt=0, s=0, r=0, state=0, busy=0, pulse_cnt=0 on the edge where rst is sampled high.
REQ-024 rst during CHECK or FIRE aborts operation; any pending pulse deasserted on that edge, state not updated, pulse_cnt not incremented.
REQ-025 After rst release with din=1, normal qualification begins on first sampling edge (no pulse earlier than REQ-015).

Verification (STABLE_CYCLES=4)
REQ-026 rst 2 cycles, din=0 -> s=r=0, state=0, busy=0, pulse_cnt=0.
REQ-027 din 0->1 held -> s=1 for exactly one cycle after 4th sampling edge, then state=1, pulse_cnt=1, busy=0.
REQ-028 state=1, din=0 for 2 cycles then 1 -> no r pulse, busy returns 0, state stays 1.
REQ-029 force_set=force_clr=1 one cycle with state=0 -> s=1 next cycle, r=0, state=1.
REQ-030 din 0->1, rst asserted during CHECK (cnt=2) -> no s pulse, state=0, pulse_cnt=0.
REQ-031 256 forced pulses from reset -> pulse_cnt=0, final state matches last force.
